// File: rtl/uart_rx_fifo1.sv
// uart_rx_fifo1: 8N1 UART receiver with a one-entry output holding register.
// The received byte sits in data/valid until the consumer pops it with ack.
// Sticky error flags (frame_err, overrun, parity_err) clear on a pop or reset.
// Optional even-parity checking is built in when UART_RX_PARITY_EN is defined;
// without it the parity state is absent and parity_err is tied low.
module uart_rx_fifo1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    // START samples mid-bit; every later sample is a full bit period apart.
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          ferr_set;
    logic          pop;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign busy = (state_q != S_IDLE);
    assign pop  = valid & ack;

    // Receiver state, bit-timer, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic: sample points fall where the timer reaches its target.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rx) state_d = S_START;
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    bit_d   = '0;
                    // A high line at mid start bit is treated as a glitch.
                    state_d = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    par_d   = rx;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    if (rx) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                timer_d = '0;
                if (rx) state_d = S_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: completion loads the byte one edge after the stop sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= 8'h00;
            valid <= 1'b0;
        end else if (done_q) begin
            data  <= shift_q;
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // Sticky flags: a set event wins over a pop on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set)   frame_err <= 1'b1;
            else if (pop)   frame_err <= 1'b0;
            // Completion with a simultaneous pop leaves overrun as it was.
            if (done_q && valid && !ack) overrun <= 1'b1;
            else if (pop && !done_q)     overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity over the delivered byte and its parity bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             parity_err <= 1'b0;
        else if (done_q && ^{shift_q, par_q}) parity_err <= 1'b1;
        else if (pop)                         parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo1.sv
// Directed bench for uart_rx_fifo1 at CLKS_PER_BIT=16.
// Inputs change on the falling clock edge; outputs are checked on falling edges.
module tb_uart_rx_fifo1;

    localparam int N = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    // Completion edge relative to t0 and last edge before it.
    localparam int LAT = PEN ? 169 : 153;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun, parity_err, busy;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    uart_rx_fifo1 #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ack(ack),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        bit         stop;
        bit         pbad;
        bit         pop;
        logic [7:0] e_data;
        bit         e_valid, e_fe, e_ov, e_pe, e_busy;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_pop();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // Drives start, data and (if built) parity bits; leaves the stop bit to the caller.
    task automatic send_start(input logic [7:0] b, input bit pbad, output int t0);
        @(negedge clk);
        rx = 1'b0;
        t0 = cyc + 1;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (N) @(negedge clk);
        end
        if (PEN) begin
            rx = (^b) ^ pbad;
            repeat (N) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [7:0] prev_data;
        bit prev_valid;

        //        byte   stop pbad pop  e_data valid fe ov pe busy
        tv[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, PEN,  1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_data", data, 8'h00);
        chk("reset_ctl", 8'({valid, frame_err, overrun, parity_err, busy}), 8'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Short low glitch: START rejects it and returns to IDLE.
        rx = 1'b0;
        t0 = cyc + 1;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        wait_to(t0 + 3);
        chk("glitch_busy_mid", 8'(busy), 8'h01);
        wait_to(t0 + 9);
        chk("glitch_idle", 8'({valid, frame_err, overrun, parity_err, busy}), 8'h00);
        repeat (4) @(negedge clk);

        prev_data  = 8'h00;
        prev_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (tv[i].pop) begin
                do_pop();
                chk("pop_valid", 8'(valid), 8'h00);
                chk("pop_flags", 8'({frame_err, overrun, parity_err}), 8'h00);
                prev_valid = 1'b0;
            end
            send_start(tv[i].b, tv[i].pbad, t0);
            rx = tv[i].stop;
            wait_to(t0 + LAT - 1);
            chk("pre_data", data, prev_data);
            chk("pre_valid", 8'(valid), 8'(prev_valid));
            wait_to(t0 + LAT);
            chk("data", data, tv[i].e_data);
            chk("valid", 8'(valid), 8'(tv[i].e_valid));
            chk("frame_err", 8'(frame_err), 8'(tv[i].e_fe));
            chk("overrun", 8'(overrun), 8'(tv[i].e_ov));
            chk("parity_err", 8'(parity_err), 8'(tv[i].e_pe));
            chk("busy", 8'(busy), 8'(tv[i].e_busy));
            if (!tv[i].stop) begin
                wait_to(t0 + LAT + 40);
                chk("break_busy", 8'(busy), 8'h01);
                rx = 1'b1;
                repeat (2) @(negedge clk);
                chk("break_exit", 8'(busy), 8'h00);
            end else begin
                wait_to(t0 + LAT + 8);
            end
            prev_data  = tv[i].e_data;
            prev_valid = tv[i].e_valid;
        end

        // Reset mid-frame while a byte is held: everything clears at once.
        @(negedge clk);
        rx = 1'b0;
        t0 = cyc + 1;
        repeat (N) @(negedge clk);
        rx = 1'b1;
        wait_to(t0 + 70);
        chk("midrst_busy_before", 8'(busy), 8'h01);
        #1 rst = 1'b0;
        #1;
        chk("midrst_data", data, 8'h00);
        chk("midrst_ctl", 8'({valid, frame_err, overrun, parity_err, busy}), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("midrst_idle", 8'(busy), 8'h00);
        send_start(8'h5A, 1'b0, t0);
        rx = 1'b1;
        wait_to(t0 + LAT);
        chk("after_rst_data", data, 8'h5A);
        chk("after_rst_ctl", 8'({valid, frame_err, overrun, parity_err}), 8'h08);
        wait_to(t0 + LAT + 8);

        // Pop on the same edge as a completion: new byte, valid held, no overrun.
        send_start(8'h96, 1'b0, t0);
        rx = 1'b1;
        wait_to(t0 + LAT - 1);
        ack = 1'b1;
        wait_to(t0 + LAT);
        ack = 1'b0;
        chk("coinc_data", data, 8'h96);
        chk("coinc_ctl", 8'({valid, frame_err, overrun, parity_err}), 8'h08);
        do_pop();
        chk("final_pop", 8'(valid), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
